// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared encodings for the multicycle MIPS controller
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
// alu_decoder : combinational ALUOp + Funct -> ALUControl
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module alu_decoder
  import mips_pkg::*;
#(
  parameter int FUNCT_W  = 6,
  parameter int ALUCTL_W = 3
) (
  input  logic [1:0]          i_alu_op,
  input  logic [FUNCT_W-1:0]  i_funct,
  output logic [ALUCTL_W-1:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        // Unknown funct codes quietly add rather than trap.
        case (i_funct)
          FN_SUB:  o_alu_control = ALU_SUB;
          FN_AND:  o_alu_control = ALU_AND;
          FN_OR:   o_alu_control = ALU_OR;
          FN_SLT:  o_alu_control = ALU_SLT;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_mc_controller.sv
// ============================================================================
// mips_mc_controller : multicycle MIPS Moore main decoder plus ALU decoder
// Rev 1.0            : initial release
// ============================================================================
`default_nettype none

module mips_mc_controller
  import mips_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUCTL_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     i_op,
  input  logic [FUNCT_W-1:0]  i_funct,
  input  logic                i_zero,
  output logic                o_iord,
  output logic                o_mem_write,
  output logic                o_ir_write,
  output logic                o_reg_dst,
  output logic                o_mem_to_reg,
  output logic                o_reg_write,
  output logic                o_alu_src_a,
  output logic [1:0]          o_alu_src_b,
  output logic [1:0]          o_pc_src,
  output logic                o_pc_en,
  output logic [ALUCTL_W-1:0] o_alu_control
);

  state_t     r_state;
  state_t     w_next;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_pc_write;
  logic       w_branch;
  logic [1:0] w_alu_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = S_FETCH;
    o_iord       = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    o_reg_dst    = 1'b0;
    o_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = SRCB_B;
    o_pc_src     = PCSRC_ALU;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    w_alu_op     = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        o_alu_src_b = SRCB_FOUR;
        w_ir_write  = 1'b1;
        w_pc_write  = 1'b1;
        w_next      = S_DECODE;
      end
      S_DECODE: begin
        o_alu_src_b = SRCB_IMM_SH;
        case (i_op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
        w_next      = (i_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        o_iord = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        o_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        o_iord      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECUTE: begin
        o_alu_src_a = 1'b1;
        w_alu_op    = ALUOP_FUNCT;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        o_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a = 1'b1;
        w_alu_op    = ALUOP_SUB;
        o_pc_src    = PCSRC_ALUOUT;
        w_branch    = 1'b1;
      end
      S_ADDIEX: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
        w_next      = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
      end
      S_JUMP: begin
        o_pc_src   = PCSRC_JUMP;
        w_pc_write = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Write enables are gated by rst_n so an interrupted write drops at once.
  assign o_mem_write = w_mem_write & rst_n;
  assign o_ir_write  = w_ir_write  & rst_n;
  assign o_reg_write = w_reg_write & rst_n;
  assign o_pc_en     = (w_pc_write | (w_branch & i_zero)) & rst_n;

  alu_decoder #(
    .FUNCT_W  (FUNCT_W),
    .ALUCTL_W (ALUCTL_W)
  ) u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct       (i_funct),
    .o_alu_control (o_alu_control)
  );

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_controller.sv
// ============================================================================
// tb_mips_mc_controller : random instruction stream against a per-instruction
//                         cycle-table model of the controller
// Rev 1.0               : initial release
// ============================================================================
`default_nettype none

module tb_mips_mc_controller;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic [2:0] alu_ctl;
  } outs_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_ADDI = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  outs_t      act;
  outs_t      exp_o;
  logic       exp_on;
  int         kind;
  int         cyc;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  mips_mc_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_op          (op),
    .i_funct       (funct),
    .i_zero        (zero),
    .o_iord        (act.iord),
    .o_mem_write   (act.mem_write),
    .o_ir_write    (act.ir_write),
    .o_reg_dst     (act.reg_dst),
    .o_mem_to_reg  (act.mem_to_reg),
    .o_reg_write   (act.reg_write),
    .o_alu_src_a   (act.alu_src_a),
    .o_alu_src_b   (act.alu_src_b),
    .o_pc_src      (act.pc_src),
    .o_pc_en       (act.pc_en),
    .o_alu_control (act.alu_ctl)
  );

  function automatic int len_of(input int k);
    case (k)
      K_LW:               return 5;
      K_SW, K_R, K_ADDI:  return 4;
      K_BEQ, K_J:         return 3;
      default:            return 2;
    endcase
  endfunction

  function automatic logic [2:0] funct_ctl(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for cycle c (0 = fetch) of an instruction of kind k.
  function automatic outs_t model(input int k, input int c, input logic [5:0] f, input logic z);
    outs_t o;
    o = '0;
    o.alu_ctl = 3'b010;
    if (c == 0) begin
      o.alu_src_b = 2'b01; o.ir_write = 1'b1; o.pc_en = 1'b1;
    end else if (c == 1) begin
      o.alu_src_b = 2'b11;
    end else begin
      case (k)
        K_LW, K_SW: begin
          if (c == 2) begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
          else if (c == 3) begin
            o.iord = 1'b1;
            o.mem_write = (k == K_SW);
          end else begin
            o.mem_to_reg = 1'b1; o.reg_write = 1'b1;
          end
        end
        K_R: begin
          if (c == 2) begin o.alu_src_a = 1'b1; o.alu_ctl = funct_ctl(f); end
          else begin o.reg_dst = 1'b1; o.reg_write = 1'b1; end
        end
        K_ADDI: begin
          if (c == 2) begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
          else o.reg_write = 1'b1;
        end
        K_BEQ: begin
          o.alu_src_a = 1'b1; o.pc_src = 2'b01; o.alu_ctl = 3'b110; o.pc_en = z;
        end
        K_J: begin
          o.pc_src = 2'b10; o.pc_en = 1'b1;
        end
        default: o = o;
      endcase
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  task automatic pick_instr();
    logic [5:0] r;
    kind = int'($urandom_range(0, 6));
    case (kind)
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      K_R:    op = 6'b000000;
      K_ADDI: op = 6'b001000;
      K_BEQ:  op = 6'b000100;
      K_J:    op = 6'b000010;
      default: begin
        r = 6'b111111;
        if ($urandom_range(0, 1) == 1) begin
          r = 6'($urandom);
          while (r == 6'b100011 || r == 6'b101011 || r == 6'b000000 ||
                 r == 6'b001000 || r == 6'b000100 || r == 6'b000010)
            r = 6'($urandom);
        end
        op = r;
      end
    endcase
    if ($urandom_range(0, 1) == 1) begin
      case ($urandom_range(0, 4))
        0: funct = 6'b100000;
        1: funct = 6'b100010;
        2: funct = 6'b100100;
        3: funct = 6'b100101;
        default: funct = 6'b101010;
      endcase
    end else begin
      funct = 6'($urandom);
    end
  endtask

  always @(negedge clk) begin
    if (exp_on) begin
      checks++;
      if (act !== exp_o) begin
        errors++;
        $display("FAIL outputs kind=%0d cyc=%0d op=%b funct=%b zero=%b: got %h expected %h",
                 kind, cyc, op, funct, zero, act, exp_o);
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    op     = 6'b100011;
    funct  = 6'b0;
    zero   = 1'b0;
    exp_on = 1'b0;
    kind   = K_LW;
    cyc    = 0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ir_write", 32'(act.ir_write), 32'd0);
    check("reset_pc_en", 32'(act.pc_en), 32'd0);
    check("reset_reg_write", 32'(act.reg_write), 32'd0);
    check("reset_alu_src_b", 32'(act.alu_src_b), 32'd1);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_ir_write", 32'(act.ir_write), 32'd1);
    check("release_pc_en", 32'(act.pc_en), 32'd1);

    // Directed lw: walk into the write-back cycle, then reset inside it.
    repeat (4) @(posedge clk);
    #1;
    check("lw_wb_reg_write", 32'(act.reg_write), 32'd1);
    check("lw_wb_mem_to_reg", 32'(act.mem_to_reg), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_reg_write", 32'(act.reg_write), 32'd0);
    check("midreset_alu_src_b", 32'(act.alu_src_b), 32'd1);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    pick_instr();
    zero  = 1'($urandom);
    exp_o = model(kind, cyc, funct, zero);
    exp_on = 1'b1;

    for (int n = 0; n < 1500; n++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == len_of(kind)) begin
        cyc = 0;
        pick_instr();
      end
      zero  = 1'($urandom);
      exp_o = model(kind, cyc, funct, zero);
    end

    @(negedge clk);
    exp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
